// File: rtl/router_dst_reader.sv
// Destination-side reader for one router output port: pulls a packet out of the
// router FIFO, streams its payload, checks parity/address/length and keeps counts.
module router_dst_reader #(
  parameter logic [1:0] PORT_ID     = 2'd0,
  parameter int         START_DELAY = 2,
  parameter int         STALL_LIMIT = 64
) (
  input  logic        clock,
  input  logic        rest,
  input  logic        valid_out,
  input  logic [7:0]  dout,
  output logic        rd_en,
  input  logic        pause,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        pkt_done,
  output logic [7:0]  pkt_hdr,
  output logic        parity_err,
  output logic        addr_err,
  output logic        len_err,
  output logic        trunc_err,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, DELAY, HDR_REQ, HDR_WAIT, BODY, DONE} state_t;

  localparam int SW = $clog2(STALL_LIMIT + 1);
  // The IDLE cycle that sees valid_out already counts as the first delay cycle.
  localparam logic [4:0]    DELAY_LAST = (START_DELAY >= 2) ? 5'(START_DELAY - 2) : 5'd0;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [7:0]    acc_q, acc_d;
  logic [6:0]    req_left_q, req_left_d;
  logic [6:0]    rcv_left_q, rcv_left_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          parity_q, parity_d;
  logic          addr_q, addr_d;
  logic          len_q, len_d;
  logic          trunc_q, trunc_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic       stall_busy;
  logic       stall_hit;
  logic [6:0] len_p1;

  assign len_p1     = {1'b0, dout[7:2]} + 7'd1;
  assign stall_busy = (state_q == HDR_REQ) || (state_q == BODY);
  assign stall_hit  = stall_busy && !valid_out && !pause && (stall_q == STALL_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    acc_d        = acc_q;
    req_left_d   = req_left_q;
    rcv_left_d   = rcv_left_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    parity_d     = parity_q;
    addr_d       = addr_q;
    len_d        = len_q;
    trunc_d      = trunc_q;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    rd_en        = 1'b0;
    stall_d      = '0;

    // Paused cycles neither advance nor clear the stall count.
    if (stall_busy) begin
      if (valid_out)   stall_d = '0;
      else if (!pause) stall_d = stall_q + SW'(1);
      else             stall_d = stall_q;
    end

    case (state_q)
      IDLE: begin
        if (valid_out) begin
          cnt_d   = 5'd0;
          state_d = (START_DELAY < 2) ? HDR_REQ : DELAY;
        end
      end
      DELAY: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DELAY_LAST) state_d = HDR_REQ;
      end
      HDR_REQ: begin
        rd_en = valid_out && !pause;
        if (stall_hit) begin
          trunc_d = 1'b1;
          state_d = DONE;
        end else if (rd_en) begin
          state_d = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        hdr_d      = dout;
        acc_d      = dout;
        req_left_d = len_p1;
        rcv_left_d = len_p1;
        parity_d   = 1'b0;
        addr_d     = (dout[1:0] != PORT_ID);
        len_d      = (dout[7:2] == 6'd0);
        trunc_d    = 1'b0;
        state_d    = BODY;
      end
      BODY: begin
        rd_en = valid_out && !pause && (req_left_q != 7'd0);
        if (rd_en) req_left_d = req_left_q - 7'd1;
        // The last byte of the packet is parity; everything before it is payload.
        if (rd_q && (rcv_left_q != 7'd0)) begin
          rcv_left_d = rcv_left_q - 7'd1;
          if (rcv_left_q > 7'd1) begin
            acc_d        = acc_q ^ dout;
            byte_data_d  = dout;
            byte_valid_d = 1'b1;
          end else begin
            parity_d = (acc_q != dout);
            state_d  = DONE;
          end
        end else if (stall_hit) begin
          trunc_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        if ((parity_q || addr_q || len_q || trunc_q) && (err_cnt_q != 16'hFFFF))
          err_cnt_d = err_cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_d = rd_en;
  end

  always_ff @(posedge clock or posedge rest) begin
    if (rest) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      hdr_q        <= '0;
      acc_q        <= '0;
      req_left_q   <= '0;
      rcv_left_q   <= '0;
      stall_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      parity_q     <= 1'b0;
      addr_q       <= 1'b0;
      len_q        <= 1'b0;
      trunc_q      <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      hdr_q        <= hdr_d;
      acc_q        <= acc_d;
      req_left_q   <= req_left_d;
      rcv_left_q   <= rcv_left_d;
      stall_q      <= stall_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      parity_q     <= parity_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      trunc_q      <= trunc_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign pkt_done   = (state_q == DONE);
  assign pkt_hdr    = hdr_q;
  assign parity_err = parity_q;
  assign addr_err   = addr_q;
  assign len_err    = len_q;
  assign trunc_err  = trunc_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_router_dst_reader.sv
// Bench for router_dst_reader: a queue stands in for the router output FIFO,
// packets come from a vector table, plus directed pause/stall/reset sequences.
module tb_router_dst_reader;

  typedef struct packed {
    logic [7:0]  hdr;
    logic [47:0] pl;
    logic [3:0]  n;
    logic [7:0]  par;
    logic [3:0]  flags;
    logic [3:0]  rds;
  } vec_t;

  logic        clock = 1'b0;
  logic        rest;
  logic        valid_out;
  logic [7:0]  dout;
  logic        rd_en;
  logic        pause;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        pkt_done;
  logic [7:0]  pkt_hdr;
  logic        parity_err;
  logic        addr_err;
  logic        len_err;
  logic        trunc_err;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] fifo[$];
  logic [7:0] got[$];
  bit         en;
  bit         pause_req;
  bit         rd_prev;
  int         step_no;
  int         done_cnt;
  int         rd_cnt;
  int         rd_viol;
  int         first_vo_step;
  int         first_rd_step;
  logic [3:0] done_flags;
  logic [7:0] done_hdr;
  int         exp_pkt;
  int         exp_err;
  vec_t       vecs[6];

  always #5 clock = ~clock;

  router_dst_reader #(.PORT_ID(2'd0), .START_DELAY(2), .STALL_LIMIT(64)) dut (
    .clock      (clock),
    .rest       (rest),
    .valid_out  (valid_out),
    .dout       (dout),
    .rd_en      (rd_en),
    .pause      (pause),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .pkt_done   (pkt_done),
    .pkt_hdr    (pkt_hdr),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .len_err    (len_err),
    .trunc_err  (trunc_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // One clock: FIFO pops after the edge that sampled rd_en, then monitor outputs.
  task automatic step();
    @(posedge clock);
    #1;
    if (rd_prev && (fifo.size() > 0)) dout = fifo.pop_front();
    valid_out = en && (fifo.size() > 0);
    pause     = pause_req;
    step_no++;
    #1;
    rd_prev = rd_en;
    if (rd_en) begin
      rd_cnt++;
      if (first_rd_step < 0) first_rd_step = step_no;
      if (!valid_out) rd_viol++;
    end
    if (valid_out && (first_vo_step < 0)) first_vo_step = step_no;
    if (byte_valid) got.push_back(byte_data);
    if (pkt_done) begin
      done_cnt++;
      done_flags = {parity_err, addr_err, len_err, trunc_err};
      done_hdr   = pkt_hdr;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_en"}, int'(rd_en), 0);
    checkOutput({tag, "_byte_valid"}, int'(byte_valid), 0);
    checkOutput({tag, "_byte_data"}, int'(byte_data), 0);
    checkOutput({tag, "_pkt_done"}, int'(pkt_done), 0);
    checkOutput({tag, "_pkt_hdr"}, int'(pkt_hdr), 0);
    checkOutput({tag, "_flags"}, int'({parity_err, addr_err, len_err, trunc_err}), 0);
    checkOutput({tag, "_pkt_cnt"}, int'(pkt_cnt), 0);
    checkOutput({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic loadPacket(input vec_t v);
    got.delete();
    done_cnt      = 0;
    rd_cnt        = 0;
    first_vo_step = -1;
    first_rd_step = -1;
    fifo.push_back(v.hdr);
    for (int i = 0; i < int'(v.n); i++) fifo.push_back(v.pl[8*i +: 8]);
    fifo.push_back(v.par);
    en = 1'b1;
  endtask

  task automatic runToDone();
    for (int c = 0; (c < 300) && (done_cnt == 0); c++) step();
    step();
    step();
  endtask

  task automatic applyStimulus(input vec_t v);
    loadPacket(v);
    runToDone();
  endtask

  task automatic expectPacket(input string tag, input vec_t v);
    exp_pkt++;
    if (v.flags != 4'b0000) exp_err++;
    checkOutput({tag, "_pkt_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_pkt_hdr"}, int'(done_hdr), int'(v.hdr));
    checkOutput({tag, "_flags"}, int'(done_flags), int'(v.flags));
    checkOutput({tag, "_byte_count"}, got.size(), int'(v.n));
    for (int i = 0; (i < int'(v.n)) && (i < got.size()); i++)
      checkOutput({tag, "_payload_byte"}, int'(got[i]), int'(v.pl[8*i +: 8]));
    checkOutput({tag, "_rd_pulses"}, rd_cnt, int'(v.rds));
    checkOutput({tag, "_pkt_cnt"}, int'(pkt_cnt), exp_pkt);
    checkOutput({tag, "_err_cnt"}, int'(err_cnt), exp_err);
  endtask

  initial begin
    vec_t stall_pkt;
    int   mark;
    int   vlow_step;
    int   done_step;

    // flags = {parity, addr, len, trunc}
    vecs[0] = '{hdr: 8'h0C, pl: 48'h0000_0033_2211, n: 4'd3, par: 8'h0C, flags: 4'b0000, rds: 4'd5};
    vecs[1] = '{hdr: 8'h0C, pl: 48'h0000_0033_2211, n: 4'd3, par: 8'hFF, flags: 4'b1000, rds: 4'd5};
    vecs[2] = '{hdr: 8'h05, pl: 48'h0000_0000_00AA, n: 4'd1, par: 8'hAF, flags: 4'b0100, rds: 4'd3};
    vecs[3] = '{hdr: 8'h00, pl: 48'h0000_0000_0000, n: 4'd0, par: 8'h00, flags: 4'b0010, rds: 4'd2};
    vecs[4] = '{hdr: 8'h10, pl: 48'h0000_0804_0201, n: 4'd4, par: 8'h1F, flags: 4'b0000, rds: 4'd6};
    vecs[5] = '{hdr: 8'h0E, pl: 48'h0000_00FF_A55A, n: 4'd3, par: 8'h00, flags: 4'b1100, rds: 4'd5};
    stall_pkt = '{hdr: 8'h14, pl: 48'h0000_0000_0201, n: 4'd2, par: 8'h00, flags: 4'b0001, rds: 4'd3};

    rest = 1'b1; valid_out = 1'b0; pause = 1'b0; dout = 8'h00;
    en = 1'b0; pause_req = 1'b0; rd_prev = 1'b0;
    step_no = 0; rd_viol = 0; exp_pkt = 0; exp_err = 0;
    done_cnt = 0; rd_cnt = 0; first_vo_step = -1; first_rd_step = -1;

    step(); step(); step();
    checkAllZero("reset");
    rest = 1'b0;
    step(); step();
    checkAllZero("idle");

    $display("[TB] table vectors");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k]);
      expectPacket($sformatf("vec%0d", k), vecs[k]);
      if (k == 0) checkOutput("start_delay", first_rd_step - first_vo_step, 2);
    end

    $display("[TB] pause mid-payload");
    loadPacket(vecs[0]);
    for (int c = 0; (c < 50) && (got.size() == 0); c++) step();
    pause_req = 1'b1;
    mark = rd_cnt;
    for (int c = 0; c < 10; c++) step();
    checkOutput("rd_during_pause", rd_cnt - mark, 0);
    pause_req = 1'b0;
    runToDone();
    expectPacket("pause", vecs[0]);

    $display("[TB] stall timeout");
    loadPacket(stall_pkt);
    fifo.pop_back();
    vlow_step = -1;
    done_step = -1;
    for (int c = 0; (c < 300) && (done_cnt == 0); c++) begin
      step();
      if ((first_vo_step >= 0) && !valid_out && (vlow_step < 0)) vlow_step = step_no;
      if ((done_cnt > 0) && (done_step < 0)) done_step = step_no;
    end
    step(); step();
    checkOutput("stall_cycles", done_step - vlow_step, 64);
    expectPacket("stall", stall_pkt);
    mark = rd_cnt;
    for (int c = 0; c < 5; c++) step();
    checkOutput("stall_idle_rd", rd_cnt - mark, 0);

    $display("[TB] reset mid-packet");
    loadPacket(vecs[4]);
    for (int c = 0; (c < 50) && (got.size() == 0); c++) step();
    mark = done_cnt;
    @(posedge clock);
    #3;
    rest = 1'b1;
    #1;
    checkAllZero("midreset");
    fifo.delete();
    en = 1'b0; rd_prev = 1'b0; dout = 8'h00;
    step(); step(); step();
    rest = 1'b0;
    step(); step();
    checkOutput("midreset_no_done", done_cnt - mark, 0);
    exp_pkt = 0;
    exp_err = 0;
    applyStimulus(vecs[0]);
    expectPacket("after_reset", vecs[0]);

    checkOutput("rd_without_valid", rd_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
